// File: rtl/exec_stage.sv
// Execute stage: ALU, branch resolution and a 32-cycle restoring divider; 1-cycle latency, 34 for divides.
// busy holds upstream while a divide runs; stall holds the pipeline registers, flush clears them and aborts a divide.
module exec_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        stall,
    input  logic [31:0] pc_in,
    input  logic [31:0] next_pc_in,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic [31:0] imm,
    input  logic [3:0]  alu_op,
    input  logic        alu_src_b,
    input  logic [2:0]  branch_type,
    input  logic        jump,
    input  logic        jalr,
    input  logic        rd_write_enable_in,
    input  logic [4:0]  rd_write_addr_in,
    input  logic [1:0]  res_src_in,
    input  logic        mem_write_enable_in,
    input  logic [2:0]  mem_width_in,
    output logic [31:0] exec_data_out,
    output logic [31:0] mem_write_data_out,
    output logic [31:0] next_pc_out,
    output logic        rd_write_enable_out,
    output logic [4:0]  rd_write_addr_out,
    output logic [1:0]  res_src_out,
    output logic        mem_write_enable_out,
    output logic [2:0]  mem_width_out,
    output logic        branch_taken,
    output logic [31:0] branch_target,
    output logic        busy
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} div_state_t;

    typedef struct packed {
        logic [31:0] exec_dat;
        logic [31:0] mem_wr_dat;
        logic [31:0] next_pc;
        logic        rd_we;
        logic [4:0]  rd_addr;
        logic [1:0]  res_src;
        logic        mem_we;
        logic [2:0]  mem_width;
    } pipe_t;

    logic [31:0] op_a, op_b, alu_res, jalr_sum;
    logic        br_cond;

    assign op_a = rs1_data;
    assign op_b = alu_src_b ? imm : rs2_data;

    always_comb begin
        alu_res = '0;
        case (alu_op)
            4'd0:    alu_res = op_a + op_b;
            4'd1:    alu_res = op_a - op_b;
            4'd2:    alu_res = op_a << op_b[4:0];
            4'd3:    alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
            4'd4:    alu_res = {31'd0, op_a < op_b};
            4'd5:    alu_res = op_a ^ op_b;
            4'd6:    alu_res = op_a >> op_b[4:0];
            4'd7:    alu_res = $signed(op_a) >>> op_b[4:0];
            4'd8:    alu_res = op_a | op_b;
            4'd9:    alu_res = op_a & op_b;
            4'd10:   alu_res = op_b;
            4'd11:   alu_res = pc_in + op_b;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        br_cond = 1'b0;
        case (branch_type)
            3'b001:  br_cond = rs1_data == rs2_data;
            3'b010:  br_cond = rs1_data != rs2_data;
            3'b011:  br_cond = $signed(rs1_data) <  $signed(rs2_data);
            3'b100:  br_cond = $signed(rs1_data) >= $signed(rs2_data);
            3'b101:  br_cond = rs1_data <  rs2_data;
            3'b110:  br_cond = rs1_data >= rs2_data;
            default: br_cond = 1'b0;
        endcase
    end

    assign jalr_sum      = rs1_data + imm;
    assign branch_target = jalr ? {jalr_sum[31:1], 1'b0} : pc_in + imm;
    assign branch_taken  = (jump | jalr | br_cond) & ~flush & ~busy;

    // Divider: ops 12..15; bit0 clear = signed, bit1 set = remainder.
    div_state_t  state_q, state_d;
    logic [4:0]  count_q, count_d;
    logic [31:0] quo_q, quo_d, rem_q, rem_d, dvsr_q, dvsr_d;
    logic        neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
    logic        rem_sel_q, rem_sel_d, special_q, special_d;

    logic        is_div, div_signed, div_start, a_neg, b_neg;
    logic [31:0] a_abs, b_abs, quo_fix, rem_fix, div_res;
    logic [32:0] rem_shift, rem_diff;

    assign is_div     = alu_op[3] & alu_op[2];
    assign div_signed = ~alu_op[0];
    assign div_start  = (state_q == S_IDLE) & is_div & ~flush;
    assign busy       = div_start | (state_q == S_RUN);

    assign a_neg = div_signed & op_a[31];
    assign b_neg = div_signed & op_b[31];
    assign a_abs = a_neg ? -op_a : op_a;
    assign b_abs = b_neg ? -op_b : op_b;

    // rem_q < dvsr_q always holds, so bit 32 of the difference is a clean borrow.
    assign rem_shift = {rem_q, quo_q[31]};
    assign rem_diff  = rem_shift - {1'b0, dvsr_q};

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvsr_d    = dvsr_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        rem_sel_d = rem_sel_q;
        special_d = special_q;
        case (state_q)
            S_IDLE: begin
                if (div_start) begin
                    rem_sel_d = alu_op[1];
                    count_d   = '0;
                    neg_quo_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    if (op_b == 32'd0) begin
                        quo_d     = 32'hFFFF_FFFF;
                        rem_d     = op_a;
                        special_d = 1'b1;
                        state_d   = S_DONE;
                    end else if (div_signed && op_a == 32'h8000_0000 && op_b == 32'hFFFF_FFFF) begin
                        quo_d     = 32'h8000_0000;
                        rem_d     = 32'd0;
                        special_d = 1'b1;
                        state_d   = S_DONE;
                    end else begin
                        quo_d     = a_abs;
                        rem_d     = 32'd0;
                        dvsr_d    = b_abs;
                        special_d = 1'b0;
                        state_d   = S_RUN;
                    end
                end
            end
            S_RUN: begin
                rem_d   = rem_diff[32] ? rem_shift[31:0] : rem_diff[31:0];
                quo_d   = {quo_q[30:0], ~rem_diff[32]};
                count_d = count_q + 5'd1;
                if (count_q == 5'd31) state_d = S_DONE;
            end
            S_DONE: begin
                if (!stall) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d = S_IDLE;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvsr_q    <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            rem_sel_q <= 1'b0;
            special_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dvsr_q    <= dvsr_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            rem_sel_q <= rem_sel_d;
            special_q <= special_d;
        end
    end

    assign quo_fix = (neg_quo_q & ~special_q) ? -quo_q : quo_q;
    assign rem_fix = (neg_rem_q & ~special_q) ? -rem_q : rem_q;
    assign div_res = rem_sel_q ? rem_fix : quo_fix;

    pipe_t pipe_q, pipe_d;

    always_comb begin
        pipe_d = pipe_q;
        if (flush) begin
            pipe_d = '0;
        end else if (!stall) begin
            if (busy) begin
                pipe_d = '0;
            end else begin
                pipe_d.exec_dat   = (state_q == S_DONE) ? div_res : alu_res;
                pipe_d.mem_wr_dat = rs2_data;
                pipe_d.next_pc    = next_pc_in;
                pipe_d.rd_we      = rd_write_enable_in;
                pipe_d.rd_addr    = rd_write_addr_in;
                pipe_d.res_src    = res_src_in;
                pipe_d.mem_we     = mem_write_enable_in;
                pipe_d.mem_width  = mem_width_in;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) pipe_q <= '0;
        else       pipe_q <= pipe_d;
    end

    assign exec_data_out        = pipe_q.exec_dat;
    assign mem_write_data_out   = pipe_q.mem_wr_dat;
    assign next_pc_out          = pipe_q.next_pc;
    assign rd_write_enable_out  = pipe_q.rd_we;
    assign rd_write_addr_out    = pipe_q.rd_addr;
    assign res_src_out          = pipe_q.res_src;
    assign mem_write_enable_out = pipe_q.mem_we;
    assign mem_width_out        = pipe_q.mem_width;

endmodule

// File: tb/tb_exec_stage.sv
// Directed bench for exec_stage: ALU ops, branches, divider timing, special cases, flush/stall/reset.
module tb_exec_stage;

    logic        clk, reset, flush, stall;
    logic [31:0] pc_in, next_pc_in, rs1_data, rs2_data, imm;
    logic [3:0]  alu_op;
    logic        alu_src_b;
    logic [2:0]  branch_type;
    logic        jump, jalr;
    logic        rd_write_enable_in, mem_write_enable_in;
    logic [4:0]  rd_write_addr_in;
    logic [1:0]  res_src_in;
    logic [2:0]  mem_width_in;
    logic [31:0] exec_data_out, mem_write_data_out, next_pc_out, branch_target;
    logic        rd_write_enable_out, mem_write_enable_out, branch_taken, busy;
    logic [4:0]  rd_write_addr_out;
    logic [1:0]  res_src_out;
    logic [2:0]  mem_width_out;

    int checks   = 0;
    int failures = 0;

    exec_stage dut (
        .clk(clk), .reset(reset), .flush(flush), .stall(stall),
        .pc_in(pc_in), .next_pc_in(next_pc_in),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
        .alu_op(alu_op), .alu_src_b(alu_src_b), .branch_type(branch_type),
        .jump(jump), .jalr(jalr),
        .rd_write_enable_in(rd_write_enable_in), .rd_write_addr_in(rd_write_addr_in),
        .res_src_in(res_src_in), .mem_write_enable_in(mem_write_enable_in),
        .mem_width_in(mem_width_in),
        .exec_data_out(exec_data_out), .mem_write_data_out(mem_write_data_out),
        .next_pc_out(next_pc_out), .rd_write_enable_out(rd_write_enable_out),
        .rd_write_addr_out(rd_write_addr_out), .res_src_out(res_src_out),
        .mem_write_enable_out(mem_write_enable_out), .mem_width_out(mem_width_out),
        .branch_taken(branch_taken), .branch_target(branch_target), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic alu_vec(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic src_b, input logic [31:0] immv,
                           input logic [31:0] exp);
        alu_op = op; rs1_data = a; rs2_data = b; alu_src_b = src_b; imm = immv;
        step();
        check_val(tag, exec_data_out, exp);
    endtask

    // Presents a divide, counts busy cycles (checking bubbles), optionally stalls in DONE.
    task automatic run_div(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp, input int exp_busy,
                           input int stall_done);
        int n;
        alu_op = op; rs1_data = a; rs2_data = b; alu_src_b = 1'b0;
        rd_write_enable_in = 1'b1; rd_write_addr_in = 5'd5; next_pc_in = 32'h204;
        #1;
        n = 0;
        while (busy && n < 40) begin
            step();
            n++;
            check_val({tag, "_bubble_dat"}, exec_data_out, 32'd0);
            check_val({tag, "_bubble_we"}, {31'd0, rd_write_enable_out}, 32'd0);
        end
        check_val({tag, "_busy_cycles"}, n, exp_busy);
        if (stall_done > 0) begin
            stall = 1'b1;
            repeat (stall_done) begin
                step();
                check_val({tag, "_stall_hold"}, exec_data_out, 32'd0);
                check_val({tag, "_stall_busy"}, {31'd0, busy}, 32'd0);
            end
            stall = 1'b0;
        end
        step();
        check_val({tag, "_result"}, exec_data_out, exp);
        check_val({tag, "_rd_we"}, {31'd0, rd_write_enable_out}, 32'd1);
        alu_op = 4'd0; rd_write_enable_in = 1'b0;
        #1;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; stall = 1'b0;
        pc_in = '0; next_pc_in = '0; rs1_data = '0; rs2_data = '0; imm = '0;
        alu_op = '0; alu_src_b = 1'b0; branch_type = '0; jump = 1'b0; jalr = 1'b0;
        rd_write_enable_in = 1'b0; rd_write_addr_in = '0; res_src_in = '0;
        mem_write_enable_in = 1'b0; mem_width_in = '0;
        #12;
        check_val("rst_exec", exec_data_out, 32'd0);
        check_val("rst_npc", next_pc_out, 32'd0);
        check_val("rst_we", {30'd0, rd_write_enable_out, mem_write_enable_out}, 32'd0);
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        step();
        reset = 1'b0;

        // ADD with immediate and all pass-through fields
        rs1_data = 32'd5; imm = 32'hFFFF_FFF9; alu_src_b = 1'b1; alu_op = 4'd0;
        rs2_data = 32'hABCD; next_pc_in = 32'h104; rd_write_enable_in = 1'b1;
        rd_write_addr_in = 5'd7; res_src_in = 2'd2; mem_write_enable_in = 1'b1; mem_width_in = 3'd3;
        step();
        check_val("add_res", exec_data_out, 32'hFFFF_FFFE);
        check_val("add_npc", next_pc_out, 32'h104);
        check_val("add_mwd", mem_write_data_out, 32'hABCD);
        check_val("add_rd", {27'd0, rd_write_addr_out}, 32'd7);
        check_val("add_misc", {25'd0, rd_write_enable_out, res_src_out, mem_write_enable_out, mem_width_out},
                  {25'd0, 1'b1, 2'd2, 1'b1, 3'd3});
        rd_write_enable_in = 1'b0; mem_write_enable_in = 1'b0;

        alu_vec("sub",   4'd1,  32'd3,          32'd5,          1'b0, 32'd0,          32'hFFFF_FFFE);
        alu_vec("sll",   4'd2,  32'd1,          32'h24,         1'b0, 32'd0,          32'h10);
        alu_vec("slt",   4'd3,  32'hFFFF_FFFF,  32'd1,          1'b0, 32'd0,          32'd1);
        alu_vec("sltu",  4'd4,  32'hFFFF_FFFF,  32'd1,          1'b0, 32'd0,          32'd0);
        alu_vec("xor",   4'd5,  32'hF0F0,       32'hFF00,       1'b0, 32'd0,          32'h0FF0);
        alu_vec("srl",   4'd6,  32'h8000_0000,  32'd31,         1'b0, 32'd0,          32'd1);
        alu_vec("sra",   4'd7,  32'h8000_0000,  32'd4,          1'b0, 32'd0,          32'hF800_0000);
        alu_vec("or",    4'd8,  32'hF0,         32'h0F,         1'b0, 32'd0,          32'hFF);
        alu_vec("and",   4'd9,  32'hF0,         32'd0,          1'b1, 32'h3C,         32'h30);
        alu_vec("lui",   4'd10, 32'h1234,       32'd0,          1'b1, 32'h1234_5000,  32'h1234_5000);
        pc_in = 32'h100;
        alu_vec("auipc", 4'd11, 32'd0,          32'd0,          1'b1, 32'h1000,       32'h1100);

        // Branches are combinational
        alu_op = 4'd0; alu_src_b = 1'b0;
        rs1_data = 32'hFFFF_FFFF; rs2_data = 32'd1; pc_in = 32'h100; imm = 32'h20;
        branch_type = 3'b011; #1;
        check_val("blt_taken", {31'd0, branch_taken}, 32'd1);
        check_val("blt_target", branch_target, 32'h120);
        branch_type = 3'b101; #1;
        check_val("bltu_taken", {31'd0, branch_taken}, 32'd0);
        branch_type = 3'b001; rs2_data = 32'hFFFF_FFFF; #1;
        check_val("beq_taken", {31'd0, branch_taken}, 32'd1);
        branch_type = 3'b000; jalr = 1'b1; rs1_data = 32'h205; imm = 32'h10; #1;
        check_val("jalr_target", branch_target, 32'h214);
        check_val("jalr_taken", {31'd0, branch_taken}, 32'd1);
        jalr = 1'b0; jump = 1'b1; flush = 1'b1; #1;
        check_val("jal_flush", {31'd0, branch_taken}, 32'd0);
        step();
        flush = 1'b0; jump = 1'b0; imm = 32'd0;

        run_div("div",    4'd12, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 33, 0);
        run_div("rem",    4'd14, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 33, 0);
        run_div("divu0",  4'd13, 32'd9,         32'd0,          32'hFFFF_FFFF, 1,  0);
        run_div("remu0",  4'd15, 32'd9,         32'd0,          32'd9,         1,  0);
        run_div("divovf", 4'd12, 32'h8000_0000, 32'hFFFF_FFFF,  32'h8000_0000, 1,  0);

        // Flush ten cycles into RUN
        alu_op = 4'd12; rs1_data = 32'd100; rs2_data = 32'd7; alu_src_b = 1'b0; #1;
        repeat (10) step();
        jump = 1'b1; #1;
        check_val("run_busy", {31'd0, busy}, 32'd1);
        check_val("run_br_blocked", {31'd0, branch_taken}, 32'd0);
        flush = 1'b1;
        step();
        flush = 1'b0; jump = 1'b0; alu_op = 4'd0; #1;
        check_val("flush_busy", {31'd0, busy}, 32'd0);
        check_val("flush_exec", exec_data_out, 32'd0);
        check_val("flush_we", {31'd0, rd_write_enable_out}, 32'd0);
        run_div("div_after_flush", 4'd13, 32'd100, 32'd7, 32'd14, 33, 0);

        run_div("remu_stall", 4'd15, 32'd100, 32'd7, 32'd2, 33, 3);

        // Stall holds pipeline while RUN continues, then async reset mid-RUN
        alu_op = 4'd0; rs1_data = 32'h11; imm = 32'h22; alu_src_b = 1'b1; rd_write_enable_in = 1'b1;
        step();
        check_val("pre_rst_add", exec_data_out, 32'h33);
        stall = 1'b1; alu_op = 4'd13; rs1_data = 32'd100; rs2_data = 32'd7; alu_src_b = 1'b0; #1;
        check_val("stall_start_busy", {31'd0, busy}, 32'd1);
        repeat (5) step();
        check_val("stall_hold_add", exec_data_out, 32'h33);
        check_val("stall_run_busy", {31'd0, busy}, 32'd1);
        #2;
        reset = 1'b1; alu_op = 4'd0; stall = 1'b0; rd_write_enable_in = 1'b0; #1;
        check_val("rst_mid_exec", exec_data_out, 32'd0);
        check_val("rst_mid_npc", next_pc_out, 32'd0);
        check_val("rst_mid_busy", {31'd0, busy}, 32'd0);
        step();
        reset = 1'b0; #1;
        check_val("post_rst_busy", {31'd0, busy}, 32'd0);
        run_div("div_after_rst", 4'd13, 32'd100, 32'd7, 32'd14, 33, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/exec_stage.md
EXEC_STAGE -- requirements
Module: exec_stage

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset.
REQ-002 SHALL have these ports, clock and reset first (name  direction  width  meaning):
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  clear the pipeline registers and abort any divide
- stall  in  1  hold the pipeline registers
- pc_in  in  32  PC of the instruction
- next_pc_in  in  32  PC+4, passed through
- rs1_data, rs2_data  in  32 each  operand values
- imm  in  32  sign-extended immediate
- alu_op  in  4  operation select (REQ-005)
- alu_src_b  in  1  operand B select: 1=imm, 0=rs2_data
- branch_type  in  3  000 none, 001 BEQ, 010 BNE, 011 BLT, 100 BGE, 101 BLTU, 110 BGEU
- jump, jalr  in  1 each  JAL / JALR
- rd_write_enable_in, rd_write_addr_in[4:0], res_src_in[1:0], mem_write_enable_in, mem_width_in[2:0]  in  passed through
- exec_data_out  out  32  registered ALU/divide result
- mem_write_data_out  out  32  registered rs2_data
- next_pc_out, rd_write_enable_out, rd_write_addr_out, res_src_out, mem_write_enable_out, mem_width_out  out  registered pass-through values
- branch_taken  out  1  combinational redirect request
- branch_target  out  32  combinational redirect address
- busy  out  1  combinational; divide in progress, upstream holds its inputs

Function
REQ-003 SHALL define A = rs1_data, and B = imm when alu_src_b=1, otherwise rs2_data.
REQ-004 SHALL register all outputs except branch_taken, branch_target and busy; latency is 1 cycle for non-divide ops.
REQ-005 SHALL encode alu_op as follows (shifts use B[4:0]; arithmetic wraps mod 2^32):
- 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA
- 8 OR, 9 AND, 10 pass B (LUI), 11 pc_in+B (AUIPC)
- 12 DIV, 13 DIVU, 14 REM, 15 REMU
REQ-006 SHALL evaluate branch conditions on rs1_data vs rs2_data, signed or unsigned per branch_type.
REQ-007 SHALL set branch_target = (rs1_data+imm) & ~1 when jalr=1, otherwise pc_in+imm.
REQ-008 SHALL set branch_taken = (jump | jalr | branch condition true) & !flush & !busy.
REQ-009 SHALL run the divider FSM IDLE -> RUN -> DONE -> IDLE:
- IDLE: on alu_op 12..15 with !flush, busy=1; at the edge, load the operands and go to RUN (count=0), or go straight to DONE if a special case applies (REQ-011).
- RUN: restoring divide of |A| by |B|, 1 bit per cycle, busy=1; after the 32nd iteration go to DONE.
- DONE: busy=0, signs applied; the pipeline registers capture the result at the next non-stalled edge, then the FSM returns to IDLE. It stays in DONE while stall=1.
REQ-010 SHALL give a non-special divide busy=1 for 33 cycles (1 IDLE cycle + 32 RUN cycles), with the result registered at the edge that ends DONE.
REQ-011 SHALL handle the divide special cases as follows, with busy=1 for exactly 1 cycle:
- B=0: quotient 0xFFFFFFFF, remainder = A.
- Signed 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0.
REQ-012 SHALL negate the quotient when the signs of A and B differ (signed ops only), and give the remainder the sign of A.
REQ-013 SHALL load a bubble into the pipeline registers while busy=1 and stall=0: rd_write_enable_out=0, mem_write_enable_out=0, all other outputs 0.
REQ-014 SHALL, on flush=1, clear the pipeline registers to 0 at the edge and force the FSM to IDLE; flush has priority over stall and busy.
REQ-015 SHALL, on stall=1 without flush, hold the pipeline registers; the divider FSM continues RUN iterations during a stall.

Reset
REQ-016 SHALL, while reset=1, drive all registered outputs to 0 and hold the FSM in IDLE with count=0, independent of clk.
REQ-017 SHALL, on reset asserted mid-divide, abort the divide; after release, busy=0 until a new divide op is presented.

Verification
REQ-018 SHALL cover ADD: A=5, imm=-7, alu_src_b=1, alu_op=0 -> exec_data_out=0xFFFFFFFE one cycle later, with pass-through fields matching the inputs.
REQ-019 SHALL cover BLT: rs1=0xFFFFFFFF, rs2=1, branch_type=011, pc_in=0x100, imm=0x20 -> branch_taken=1, branch_target=0x120 in the same cycle; BLTU with the same operands -> branch_taken=0.
REQ-020 SHALL cover DIV: -7 / 2 -> busy high for 33 cycles, bubbles meanwhile, then exec_data_out=0xFFFFFFFD; REM on the same operands -> 0xFFFFFFFF.
REQ-021 SHALL cover the special cases: DIVU 9/0 -> 0xFFFFFFFF with busy high for 1 cycle; DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
REQ-022 SHALL cover flush at RUN cycle 10 -> busy low next cycle, outputs 0, and the next divide completes normally.
REQ-023 SHALL cover stall held 3 cycles while in DONE -> result held and registered on the first non-stalled edge; reset pulse mid-RUN -> all outputs 0, busy=0.
